// File: rtl/rgb_seq_pkg.sv
// Shared state type, palette constants and small helpers for the RGB fade sequencer.
package rgb_seq_pkg;

  localparam int DUTY_W      = 8;
  localparam int PALETTE_LEN = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  // Palette entries are packed R,G,B from MSB to LSB.
  localparam logic [23:0] PAL_RED     = 24'hFF0000;
  localparam logic [23:0] PAL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] PAL_GREEN   = 24'h00FF00;
  localparam logic [23:0] PAL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] PAL_BLUE    = 24'h0000FF;
  localparam logic [23:0] PAL_MAGENTA = 24'hFF00FF;

  function automatic logic [23:0] paletteRgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = PAL_RED;
      3'd1:    rgb = PAL_YELLOW;
      3'd2:    rgb = PAL_GREEN;
      3'd3:    rgb = PAL_CYAN;
      3'd4:    rgb = PAL_BLUE;
      3'd5:    rgb = PAL_MAGENTA;
      default: rgb = PAL_RED;
    endcase
    return rgb;
  endfunction

  function automatic logic [2:0] nextIndex(input logic [2:0] idx);
    logic [2:0] nxt;
    if (idx >= 3'(PALETTE_LEN - 1)) nxt = 3'd0;
    else                            nxt = idx + 3'd1;
    return nxt;
  endfunction

  function automatic logic [DUTY_W-1:0] stepToward(input logic [DUTY_W-1:0] cur,
                                                   input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] nxt;
    if (cur < tgt)      nxt = cur + DUTY_W'(1);
    else if (cur > tgt) nxt = cur - DUTY_W'(1);
    else                nxt = cur;
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Shared 8-bit PWM carrier: a clock divider feeding a free-running 8-bit ramp,
// plus a one-cycle period_tick on the last clock of every carrier period.
module pwm_carrier
  import rgb_seq_pkg::*;
#(
  parameter int PWM_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [DUTY_W-1:0] o_carrier,
  output logic              o_period_tick
);

  localparam int              DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

  logic [DIV_W-1:0]  r_div;
  logic [DUTY_W-1:0] r_carrier;
  logic              w_divWrap;

  assign w_divWrap = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_carrier <= '0;
    end else if (w_divWrap) begin
      r_div     <= '0;
      r_carrier <= r_carrier + DUTY_W'(1);
    end else begin
      r_div     <= r_div + DIV_W'(1);
    end
  end

  assign o_carrier     = r_carrier;
  assign o_period_tick = w_divWrap && (r_carrier == '1);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps the RGB LEDs through a six-colour palette with linear fades and holds.
// Define RGB_ACTIVE_LOW_EN for common-anode LEDs (owvrgbled inverted, resets to 3'b111).
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int SYS_FREQ   = 60_000_000,
  parameter int PWM_DIV    = 2,
  parameter int STEP_DIV   = 4,
  parameter int HOLD_STEPS = 200
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        ien,
  input  logic        ikey_next,
  output logic [2:0]  owvrgbled,
  output logic [23:0] ovduty,
  output logic [2:0]  ovindex,
  output logic        ostep_done
);

  if (SYS_FREQ < 1 || PWM_DIV < 1 || STEP_DIV < 1 || HOLD_STEPS < 1) begin : gBadParams
    $error("rgb_fade_sequencer: SYS_FREQ, PWM_DIV, STEP_DIV and HOLD_STEPS must be >= 1");
  end

  localparam int               STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int               HOLD_W    = $clog2(HOLD_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(HOLD_STEPS);

`ifdef RGB_ACTIVE_LOW_EN
  localparam logic [2:0] LED_POLARITY = 3'b111;
`else
  localparam logic [2:0] LED_POLARITY = 3'b000;
`endif

  seq_state_e        r_state;
  seq_state_e        w_nextState;

  logic [DUTY_W-1:0] w_carrier;
  logic              w_periodTick;
  logic              w_stepTick;
  logic [STEP_W-1:0] r_stepCnt;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [HOLD_W-1:0] w_holdNext;

  logic [23:0]       r_duty;
  logic [23:0]       w_targetRgb;
  logic [23:0]       w_target;
  logic [23:0]       w_stepDuty;
  logic [2:0]        r_index;
  logic              r_stepDone;
  logic [2:0]        r_led;
  logic [2:0]        w_cmp;

  logic              w_fadeDone;
  logic              w_holdExit;
  logic              w_dutyStep;
  logic              w_doneSet;
  logic              w_holdInc;
  logic              w_advance;

  pwm_carrier #(
    .PWM_DIV (PWM_DIV)
  ) u_carrier (
    .i_clk         (iclk),
    .i_rst_n       (irst_n),
    .o_carrier     (w_carrier),
    .o_period_tick (w_periodTick)
  );

  assign w_stepTick = w_periodTick && (r_stepCnt == STEP_LAST);
  assign w_holdNext = r_holdCnt + HOLD_W'(1);
  assign w_holdExit = ikey_next || (w_stepTick && (w_holdNext == HOLD_END));

  // Duty registers are packed {B,G,R}; the palette is R,G,B, so reorder once here.
  always_comb begin
    w_targetRgb = paletteRgb(r_index);
    w_target    = {w_targetRgb[7:0], w_targetRgb[15:8], w_targetRgb[23:16]};
    w_stepDuty  = r_duty;
    w_cmp       = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_stepDuty[ch*DUTY_W +: DUTY_W] = stepToward(r_duty[ch*DUTY_W +: DUTY_W],
                                                   w_target[ch*DUTY_W +: DUTY_W]);
      w_cmp[ch] = (r_duty[ch*DUTY_W +: DUTY_W] > w_carrier);
    end
    w_fadeDone = (w_stepDuty == w_target);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (!ien) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = FADE;
        FADE:    if (w_stepTick && w_fadeDone) w_nextState = HOLD;
        HOLD:    if (w_holdExit) w_nextState = FADE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_dutyStep = 1'b0;
    w_doneSet  = 1'b0;
    w_holdInc  = 1'b0;
    w_advance  = 1'b0;
    if (ien) begin
      case (r_state)
        FADE: begin
          w_dutyStep = w_stepTick;
          w_doneSet  = w_stepTick && w_fadeDone;
        end
        HOLD: begin
          w_holdInc = w_stepTick;
          w_advance = w_holdExit;
        end
        default: ;
      endcase
    end
  end

  // Step divider only runs while sequencing so a re-enable starts a fresh count.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_stepCnt <= '0;
    end else if (!ien || r_state == IDLE) begin
      r_stepCnt <= '0;
    end else if (w_periodTick) begin
      r_stepCnt <= (r_stepCnt == STEP_LAST) ? '0 : r_stepCnt + STEP_W'(1);
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_duty     <= '0;
      r_index    <= '0;
      r_holdCnt  <= '0;
      r_stepDone <= 1'b0;
    end else begin
      r_stepDone <= w_doneSet;
      if (!ien) begin
        r_duty    <= '0;
        r_holdCnt <= '0;
      end else begin
        if (w_dutyStep) r_duty <= w_stepDuty;
        if (w_doneSet)      r_holdCnt <= '0;
        else if (w_holdInc) r_holdCnt <= w_holdNext;
        if (w_advance) r_index <= nextIndex(r_index);
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_led <= LED_POLARITY;
    else         r_led <= w_cmp ^ LED_POLARITY;
  end

  assign owvrgbled  = r_led;
  assign ovduty     = r_duty;
  assign ovindex    = r_index;
  assign ostep_done = r_stepDone;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer: per-cycle palette/fade model plus directed checks.
module tb_rgb_fade_sequencer;

  localparam int PWM_DIV    = 1;
  localparam int STEP_DIV   = 1;
  localparam int HOLD_STEPS = 2;
  localparam int FADE_BOUND = 70000;
  localparam int M_IDLE = 0;
  localparam int M_FADE = 1;
  localparam int M_HOLD = 2;

`ifdef RGB_ACTIVE_LOW_EN
  localparam logic [2:0] LED_POL = 3'b111;
`else
  localparam logic [2:0] LED_POL = 3'b000;
`endif

  logic        iclk      = 1'b0;
  logic        irst_n    = 1'b1;
  logic        ien       = 1'b0;
  logic        ikey_next = 1'b0;
  logic [2:0]  owvrgbled;
  logic [23:0] ovduty;
  logic [2:0]  ovindex;
  logic        ostep_done;

  int assertCount = 0;
  int failCount   = 0;

  rgb_fade_sequencer #(
    .SYS_FREQ   (60_000_000),
    .PWM_DIV    (PWM_DIV),
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .ien        (ien),
    .ikey_next  (ikey_next),
    .owvrgbled  (owvrgbled),
    .ovduty     (ovduty),
    .ovindex    (ovindex),
    .ostep_done (ostep_done)
  );

  always #5 iclk = ~iclk;

  int palR[6] = '{255, 255,   0,   0,   0, 255};
  int palG[6] = '{  0, 255, 255, 255,   0,   0};
  int palB[6] = '{  0,   0,   0, 255, 255, 255};

  int         mMode, mIdx, mHold, mClock, mPeriods;
  int         mDuty[3];
  logic [2:0] mLed;
  logic       mDone;
  bit         checkEn = 1'b0;

  function automatic int targetOf(input int idx, input int ch);
    if (ch == 0) return palR[idx];
    if (ch == 1) return palG[idx];
    return palB[idx];
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mIdx = 0; mHold = 0; mClock = 0; mPeriods = 0;
    for (int ch = 0; ch < 3; ch++) mDuty[ch] = 0;
    mLed = 3'b000; mDone = 1'b0;
  endtask

  // One clock of the sequencer, evaluated from the pre-edge values.
  task automatic modelStep();
    int  carrier;
    bit  periodTick, stepTick, allEq;
    carrier    = (mClock / PWM_DIV) % 256;
    periodTick = ((mClock + 1) % (256 * PWM_DIV)) == 0;
    stepTick   = periodTick && ((mPeriods % STEP_DIV) == STEP_DIV - 1);
    for (int ch = 0; ch < 3; ch++) mLed[ch] = (mDuty[ch] > carrier);
    mDone = 1'b0;
    if (mMode == M_IDLE || !ien) mPeriods = 0;
    else if (periodTick)          mPeriods++;
    if (!ien) begin
      mMode = M_IDLE; mHold = 0;
      for (int ch = 0; ch < 3; ch++) mDuty[ch] = 0;
    end else if (mMode == M_IDLE) begin
      mMode = M_FADE;
    end else if (mMode == M_FADE) begin
      if (stepTick) begin
        allEq = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
          if (mDuty[ch] < targetOf(mIdx, ch))      mDuty[ch]++;
          else if (mDuty[ch] > targetOf(mIdx, ch)) mDuty[ch]--;
          if (mDuty[ch] != targetOf(mIdx, ch)) allEq = 1'b0;
        end
        if (allEq) begin mDone = 1'b1; mMode = M_HOLD; mHold = 0; end
      end
    end else begin
      if (stepTick) mHold++;
      if (ikey_next || (stepTick && mHold == HOLD_STEPS)) begin
        mIdx = (mIdx + 1) % 6; mMode = M_FADE;
      end
    end
    mClock++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareOutputs();
    logic [23:0] expDuty;
    logic [2:0]  expLed;
    expDuty = {8'(mDuty[2]), 8'(mDuty[1]), 8'(mDuty[0])};
    expLed  = mLed ^ LED_POL;
    assertCount++;
    if (owvrgbled !== expLed || ovduty !== expDuty || ovindex !== 3'(mIdx) || ostep_done !== mDone) begin
      failCount++;
      $display("[TB] FAIL model_cycle t=%0t: got led=%b duty=%06h idx=%0d done=%b, expected led=%b duty=%06h idx=%0d done=%b",
               $time, owvrgbled, ovduty, ovindex, ostep_done, expLed, expDuty, mIdx, mDone);
    end
  endtask

  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      modelReset();
      checkEn = 1'b1;
    end else begin
      modelStep();
    end
    #1;
    if (checkEn) compareOutputs();
  end

  // Called on a falling edge: drive inputs now, advance one cycle, drop the key pulse.
  task automatic applyStimulus(input logic en, input logic key);
    ien       = en;
    ikey_next = key;
    @(negedge iclk);
    ikey_next = 1'b0;
  endtask

  task automatic waitForDone(input string name);
    int n = 0;
    while (ostep_done !== 1'b1 && n < FADE_BOUND) begin
      @(negedge iclk);
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(ostep_done), 32'd1);
  endtask

  task automatic waitForDuty(input logic [23:0] duty, input int bound);
    int n = 0;
    while (ovduty !== duty && n < bound) begin
      @(negedge iclk);
      n++;
    end
    checkOutput("duty_reached", 32'(ovduty), 32'(duty));
  endtask

  initial begin
    logic ledOn;
    int   highCnt;

    #2 irst_n = 1'b0;
    repeat (3) @(negedge iclk);
    checkOutput("reset_duty",  32'(ovduty),    32'h0);
    checkOutput("reset_index", 32'(ovindex),   32'h0);
    checkOutput("reset_led",   32'(owvrgbled), 32'(LED_POL));
    checkOutput("reset_done",  32'(ostep_done), 32'h0);
    irst_n = 1'b1;
    $display("[TB] enable, fading towards red");
    applyStimulus(1'b1, 1'b0);

    waitForDuty(24'h000040, 70 * 256);
    highCnt = 0;
    for (int k = 0; k < 256; k++) begin
      ledOn = (owvrgbled[0] != LED_POL[0]);
      if (k == 0)  checkOutput("pwm_off_offset0",  32'(ledOn), 32'd0);
      if (k == 64) checkOutput("pwm_on_offset64",  32'(ledOn), 32'd1);
      if (k == 65) checkOutput("pwm_off_offset65", 32'(ledOn), 32'd0);
      highCnt += ledOn;
      @(negedge iclk);
    end
    checkOutput("pwm_high_count", 32'(highCnt), 32'd64);
    checkOutput("fade_next_step", 32'(ovduty),  32'h000041);

    applyStimulus(1'b1, 1'b1);
    checkOutput("key_in_fade_ignored", 32'(ovindex), 32'd0);

    waitForDone("red");
    checkOutput("red_duty",  32'(ovduty),  32'h0000FF);
    checkOutput("red_index", 32'(ovindex), 32'd0);
    repeat (511) @(negedge iclk);
    checkOutput("hold_last_cycle", 32'(ovindex), 32'd0);
    @(negedge iclk);
    checkOutput("hold_expired",    32'(ovindex), 32'd1);

    repeat (1000) @(negedge iclk);
    $display("[TB] dropping enable mid-fade");
    applyStimulus(1'b0, 1'b0);
    checkOutput("disable_duty",  32'(ovduty),  32'h0);
    checkOutput("disable_index", 32'(ovindex), 32'd1);
    repeat (4) @(negedge iclk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reenable_index", 32'(ovindex), 32'd1);

    waitForDone("yellow");
    checkOutput("yellow_duty", 32'(ovduty), 32'h00FFFF);
    applyStimulus(1'b1, 1'b1);
    checkOutput("key_first_hold_cycle", 32'(ovindex), 32'd2);

    waitForDone("green");
    checkOutput("green_duty", 32'(ovduty), 32'h00FF00);
    applyStimulus(1'b1, 1'b1);
    checkOutput("to_cyan", 32'(ovindex), 32'd3);

    waitForDone("cyan");
    checkOutput("cyan_duty", 32'(ovduty), 32'hFFFF00);
    applyStimulus(1'b1, 1'b1);
    checkOutput("to_blue", 32'(ovindex), 32'd4);

    waitForDone("blue");
    checkOutput("blue_duty", 32'(ovduty), 32'hFF0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("to_magenta", 32'(ovindex), 32'd5);

    waitForDone("magenta");
    checkOutput("magenta_duty", 32'(ovduty), 32'hFF00FF);
    applyStimulus(1'b1, 1'b1);
    checkOutput("wrap_index", 32'(ovindex), 32'd0);
    repeat (767) @(negedge iclk);
    checkOutput("wrap_blue_fades_red_holds", 32'(ovduty), 32'hFC00FF);

    $display("[TB] asynchronous reset mid-run");
    #2 irst_n = 1'b0;
    #1;
    checkOutput("async_reset_duty",  32'(ovduty),    32'h0);
    checkOutput("async_reset_index", 32'(ovindex),   32'h0);
    checkOutput("async_reset_led",   32'(owvrgbled), 32'(LED_POL));
    repeat (2) @(negedge iclk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Colour-sequencing controller for the on-board RGB LEDs. Owns a shared 8-bit PWM carrier and three per-channel duty registers, and steps through a fixed six-colour palette. Fades linearly from the current colour to the next, holds, then advances. Sits between the board top and the RGB LED pins, replacing free-running triangle counters with a deterministic, key-advanceable sequence.

## Interface
- SYS_FREQ, 60_000_000: system clock frequency in Hz; documentation only, no logic depends on it.
- PWM_DIV, 2: clocks per carrier increment, ≥1; PWM frequency = SYS_FREQ/(256·PWM_DIV).
- STEP_DIV, 4: PWM periods per fade step, ≥1.
- HOLD_STEPS, 200: step ticks spent in HOLD, ≥1.
- iclk  in  1: system clock, single clock domain.
- irst_n  in  1: asynchronous, active-low reset.
- ien  in  1: sequence enable, synchronous to iclk.
- ikey_next  in  1: one-cycle pulse, already debounced; ends HOLD early.
- owvrgbled  out  3: PWM outputs, [0]=R, [1]=G, [2]=B; registered.
- ovduty  out  24: current duties {B,G,R}, 8 bits each.
- ovindex  out  3: palette index of the current target, 0..5.
- ostep_done  out  1: one-cycle pulse when a fade reaches its target.

## Operation
- Palette in index order: 0 red FF0000, 1 yellow FFFF00, 2 green 00FF00, 3 cyan 00FFFF, 4 blue 0000FF, 5 magenta FF00FF. Values are R,G,B duty.
- Carrier: divider counts 0..PWM_DIV-1. The 8-bit carrier increments on divider wrap and wraps 255→0.
- period_tick: carrier==255 and divider wrap.
- step_tick: every STEP_DIV-th period_tick.
- FSM states:
  - IDLE: duties 0. Entered when ien=0 from any state.
  - FADE: entered from IDLE when ien=1, or from HOLD on exit.
  - HOLD.
- FADE: on each step_tick, each channel moves 1 toward its palette[ovindex] value; a channel already equal to its target is unchanged.
  - When all three channels equal their targets after an update: ostep_done pulses and the FSM goes to HOLD with the hold counter cleared.
- HOLD: counts step_ticks. Exit when the count reaches HOLD_STEPS, or on ikey_next=1, whichever comes first.
  - On exit: ovindex ← (ovindex+1) mod 6 (5 wraps to 0) and the FSM goes to FADE.
- ikey_next is ignored in IDLE and FADE.
- Leaving IDLE: ovindex is kept, not reset, so the sequence resumes at the same target.
- Duty changes only on step_tick, which coincides with carrier wrap, so no PWM period ever contains two duty values.
- Compare: channel on when duty > carrier. Duty 0 is never on; duty 255 is on 255 of every 256 carrier counts.
- ien falling mid-FADE or mid-HOLD: next cycle state=IDLE, duties 0, step/hold counters cleared. Carrier keeps running.
- Simultaneous events: ien=0 overrides ikey_next and all ticks. A HOLD_STEPS expiry coinciding with ikey_next causes a single advance.

## Timing
- Reset values:
  - state IDLE, ovindex 0, ovduty 0, ostep_done 0.
  - carrier and all counters 0.
  - owvrgbled 3'b000, or 3'b111 with RGB_ACTIVE_LOW_EN.
- owvrgbled is registered: it reflects the compare of duty and carrier from the previous cycle (1-cycle latency).
- ovduty and ostep_done update in the cycle after step_tick.
- ien=1 in IDLE: FADE from the next cycle. First duty change at the next step_tick.
- Full fade of one channel 0→255: 255 step_ticks = 255·STEP_DIV·256·PWM_DIV clocks.

## Configuration
- RGB_ACTIVE_LOW_EN defined: owvrgbled is inverted (1 = LED off), for the board's common-anode RGB LEDs. Reset value is 3'b111.
- Undefined: active-high outputs, reset value 3'b000.
- ovduty is unaffected either way.

## Structure
- Package rgb_seq_pkg holds:
  - state enum IDLE/FADE/HOLD;
  - the six 24-bit palette constants and PALETTE_LEN=6;
  - DUTY_W=8.
- Sub-module pwm_carrier holds the divider, the 8-bit carrier and period_tick generation; parameter PWM_DIV.
- The FSM, duty registers and compare stay in the top.

## Test plan
Bench parameters: PWM_DIV=1, STEP_DIV=1, HOLD_STEPS=2.
- Reset: irst_n=0 mid-run → owvrgbled=0, ovduty=0, ovindex=0, state IDLE, asynchronously.
- Fade to red: ien=1 → R rises by 1 every 256 clocks.
  - ostep_done fires once when ovduty=0x0000FF.
  - Then HOLD lasts 512 clocks, then ovindex=1.
- PWM compare: R duty=0x40 → owvrgbled[0] high for exactly 64 of every 256 clocks, delayed 1 cycle from carrier.
- ikey_next early exit: pulse in the first HOLD cycle → ovindex advances on the next cycle. A pulse during FADE → no effect.
- Wrap: after magenta (index 5) → ovindex=0, and the R channel stays 0xFF while B fades down.
- ien dropped mid-FADE → ovduty=0 on the next clock. Re-enable → fade resumes toward the same ovindex.
